// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the slice-serial adder sequencer.
// Optional subtract mode is enabled with the ADDSEQ_SUB_EN macro (see adder_seq_ctrl).
package adder_seq_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    // A single-slice build still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/full_adder_4b.sv
// 4-bit ripple-carry adder slice; the only arithmetic element in the sequencer.
module full_adder_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = c_in;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign c_out = c[4];

endmodule

// File: rtl/adder_seq_ctrl.sv
// Multi-cycle WIDTH-bit adder that feeds one 4-bit slice per cycle through full_adder_4b.
// Define ADDSEQ_SUB_EN to add the in_sub port (A-B via inverted B and carry-in of 1).
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef ADDSEQ_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned CNT_W  = cnt_width(NSLICE);

    generate
        if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
            $error("adder_seq_ctrl: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q, cout_q, ovf_q;

    logic [SLICE_W-1:0] a_sl, b_sl, fa_sum;
    logic               fa_cout;
    logic               accept, last_slice, ovf_calc;
    logic [WIDTH-1:0]   b_load;
    logic               c_load;

    always_comb begin
`ifdef ADDSEQ_SUB_EN
        b_load = in_sub ? ~in_b : in_b;
        c_load = in_sub ? 1'b1 : in_cin;
`else
        b_load = in_b;
        c_load = in_cin;
`endif
    end

    // Slice mux over constant indices keeps the select logic explicit.
    always_comb begin
        a_sl  = '0;
        b_sl  = '0;
        sum_d = sum_q;
        for (int i = 0; i < int'(NSLICE); i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_sl = a_q[i*SLICE_W +: SLICE_W];
                b_sl = b_q[i*SLICE_W +: SLICE_W];
                sum_d[i*SLICE_W +: SLICE_W] = fa_sum;
            end
        end
    end

    full_adder_4b u_fa (
        .a     (a_sl),
        .b     (b_sl),
        .c_in  (carry_q),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    assign accept     = (state_q == StIdle) && in_valid;
    assign last_slice = (cnt_q == CNT_W'(NSLICE - 1));
    // Top slice's MSB is the result sign; b_q already holds the inverted operand when subtracting.
    assign ovf_calc   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (fa_sum[SLICE_W-1] != a_q[WIDTH-1]);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_valid) state_d = StRun;
            StRun:  if (last_slice) state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q     <= in_a;
                b_q     <= b_load;
                carry_q <= c_load;
                cnt_q   <= '0;
            end else if (state_q == StRun) begin
                sum_q   <= sum_d;
                carry_q <= fa_cout;
                if (last_slice) begin
                    cout_q <= fa_cout;
                    ovf_q  <= ovf_calc;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench for adder_seq_ctrl: driver pushes expected results, a monitor pops and checks.
// Exercises subtract mode too when compiled with ADDSEQ_SUB_EN.
module tb_adder_seq_ctrl;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned NSLICE = WIDTH / 4;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_cin = 1'b0;
`ifdef ADDSEQ_SUB_EN
    logic             in_sub = 1'b0;
`endif
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   neg_cnt = 0;
    bit   rdy_rand = 1'b0;
    exp_t exp_q[$];
    int   acc_q[$];

    adder_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef ADDSEQ_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    // Reference: integer arithmetic on the operand values, overflow as signed range escape.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        exp_t             m;
        logic [WIDTH-1:0] bp;
        longint           full, sres;
        int               c;
        bp   = sub ? ~b : b;
        c    = sub ? 1 : int'(cin);
        full = longint'(a) + longint'(bp) + longint'(c);
        sres = longint'($signed(a)) + longint'($signed(bp)) + longint'(c);
        m.sum  = full[WIDTH-1:0];
        m.cout = full >= (longint'(1) << WIDTH);
        m.ovf  = (sres > 32767) || (sres < -32768);
        return m;
    endfunction

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                        input logic sub, input bit expect_res, input exp_t e);
        bit accepted = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
`ifdef ADDSEQ_SUB_EN
        in_sub   = sub;
`endif
        for (int i = 0; i < 64 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                if (expect_res) exp_q.push_back(e);
            end
        end
        if (!accepted) fail_now("accept");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = WIDTH'($urandom);
        in_b     = WIDTH'($urandom);
        in_cin   = 1'(($urandom));
    endtask

    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin : monitor
        bit               prev_valid = 1'b0;
        bit               held = 1'b0;
        logic [WIDTH-1:0] h_sum;
        logic             h_cout, h_ovf;
        exp_t             e;
        int               acc;
        forever begin
            @(negedge clk);
            neg_cnt++;
            if (rst) begin
                acc_q.delete();
                prev_valid = 1'b0;
                held       = 1'b0;
                continue;
            end
            if (held) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_sum", out_sum, h_sum);
                check("hold_cout", out_cout, h_cout);
                check("hold_ovf", out_ovf, h_ovf);
            end
            if (out_valid && !prev_valid) begin
                if (acc_q.size() == 0) begin
                    fail_now("latency_no_accept");
                end else begin
                    acc = acc_q.pop_front();
                    check("latency", neg_cnt - acc, NSLICE + 1);
                end
            end
            if (out_valid) check("done_in_ready", in_ready, 1'b0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("spurious_result");
                end else begin
                    e = exp_q.pop_front();
                    check("sum", out_sum, e.sum);
                    check("cout", out_cout, e.cout);
                    check("ovf", out_ovf, e.ovf);
                end
            end
            held       = out_valid && !out_ready;
            h_sum      = out_sum;
            h_cout     = out_cout;
            h_ovf      = out_ovf;
            prev_valid = out_valid;
            if (in_valid && in_ready) acc_q.push_back(neg_cnt);
        end
    end

    initial begin : driver
        logic [WIDTH-1:0] ra, rb;
        logic             rc, rs;
        bit               got;
        exp_t             e2;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", out_sum, 0);
        check("rst_cout", out_cout, 0);
        check("rst_ovf", out_ovf, 0);

        rdy_rand = 1'b1;
        send(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b1, '{sum: 16'h2233, cout: 1'b0, ovf: 1'b0});
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0});
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, '{sum: 16'h8000, cout: 1'b0, ovf: 1'b1});
`ifdef ADDSEQ_SUB_EN
        send(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, '{sum: 16'hFFFE, cout: 1'b0, ovf: 1'b0});
`endif

        // Backpressure: result held while new operands wait, then accepted straight from IDLE.
        rdy_rand = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 40 && (out_valid || exp_q.size() != 0); i++) begin
            @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, '{sum: 16'h3333, cout: 1'b0, ovf: 1'b0});
        in_valid = 1'b1;
        in_a     = 16'hABCD;
        in_b     = 16'h1234;
        in_cin   = 1'b1;
        got      = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            check("bp_busy_in_ready", in_ready, 1'b0);
            if (out_valid) got = 1'b1;
        end
        if (!got) fail_now("bp_wait_valid");
        repeat (2) begin
            @(negedge clk);
            check("bp_done_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_idle_in_ready", in_ready, 1'b1);
        check("bp_idle_out_valid", out_valid, 1'b0);
        e2 = model(16'hABCD, 16'h1234, 1'b1, 1'b0);
        exp_q.push_back(e2);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_second_taken", in_ready, 1'b0);
        rdy_rand = 1'b1;

        // Reset during the second RUN cycle discards the operation.
        for (int i = 0; i < 60 && (exp_q.size() != 0 || out_valid); i++) @(posedge clk);
        send(16'h4321, 16'h1111, 1'b0, 1'b0, 1'b0, '{sum: '0, cout: 1'b0, ovf: 1'b0});
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_sum", out_sum, 0);
        check("mid_rst_cout", out_cout, 0);
        check("mid_rst_ovf", out_ovf, 0);
        repeat (12) @(posedge clk);

        for (int n = 0; n < 40; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
`ifdef ADDSEQ_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            if (n % 8 == 0) ra = 16'h7FFF;
            if (n % 8 == 1) rb = 16'h8000;
            send(ra, rb, rc, rs, 1'b1, model(ra, rb, rc, rs));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        rdy_rand = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 200 && (exp_q.size() != 0 || out_valid); i++) @(posedge clk);
        repeat (10) @(posedge clk);
        check("drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
